// File: rtl/hazard_controller_if.sv
// Hazard controller port bundle: decode/EX/MEM observations in, pipeline control and counters out.
interface hazard_controller_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic [4:0]           id_rs1;
    logic [4:0]           id_rs2;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic [4:0]           ex_rd;
    logic                 ex_mem_read;
    logic                 ex_branch_taken;
    logic                 mem_req;
    logic                 mem_ready;
    logic                 pc_write;
    logic                 if_id_write;
    logic                 if_id_flush;
    logic                 id_ex_flush;
    logic                 mem_stall;
    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] flush_events;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, mem_stall, state,
               stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, mem_stall, state,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and data-memory wait stalls,
// with Mealy control outputs and saturating stall/flush performance counters.
module hazard_controller #(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_controller_if.slave  hz
);
    localparam int unsigned BUB_W = 2;
    localparam logic [BUB_W-1:0] BUB_RELOAD = BUB_W'(LOAD_BUBBLES - 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    state_t               ret_q, ret_d;
    state_t               eff_c;
    logic [BUB_W-1:0]     bub_q, bub_d;
    logic [CNT_WIDTH-1:0] stall_q, flush_q;

    logic hazard_c;
    logic mem_wait_c;
    logic br_flush_c;
    logic pc_write_c;
    logic if_id_write_c;
    logic if_id_flush_c;
    logic id_ex_flush_c;
    logic mem_stall_c;

    // Priority: memory wait > taken branch > load-use bubble > normal run.
    // In MEM_WAIT the release cycle behaves as the saved state, so a held branch flushes there.
    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        bub_d         = bub_q;
        br_flush_c    = 1'b0;
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        mem_stall_c   = 1'b0;

        hazard_c = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                   ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                    (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));
        mem_wait_c = (state_q == MEM_WAIT) ? !hz.mem_ready : (hz.mem_req && !hz.mem_ready);
        eff_c      = (state_q == MEM_WAIT) ? ret_q : state_q;

        if (mem_wait_c) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            mem_stall_c   = 1'b1;
            state_d       = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                ret_d = state_q;
            end
        end else if (hz.ex_branch_taken) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            br_flush_c    = 1'b1;
            state_d       = RUN;
            ret_d         = RUN;
            bub_d         = '0;
        end else if (eff_c == LOAD_STALL) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            id_ex_flush_c = 1'b1;
            bub_d         = bub_q - BUB_W'(1);
            state_d       = (bub_q <= BUB_W'(1)) ? RUN : LOAD_STALL;
            ret_d         = RUN;
        end else if (hazard_c) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            id_ex_flush_c = 1'b1;
            ret_d         = RUN;
            if (LOAD_BUBBLES > 1) begin
                state_d = LOAD_STALL;
                bub_d   = BUB_RELOAD;
            end else begin
                state_d = RUN;
            end
        end else begin
            state_d = RUN;
            ret_d   = RUN;
        end

        // Reset forces a NOP-filled, frozen front end independent of the clock.
        if (!rst) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            mem_stall_c   = 1'b0;
            br_flush_c    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            bub_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            bub_q   <= bub_d;
            if (!pc_write_c && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_WIDTH'(1);
            end
            if (br_flush_c && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_WIDTH'(1);
            end
        end
    end

    assign hz.pc_write     = pc_write_c;
    assign hz.if_id_write  = if_id_write_c;
    assign hz.if_id_flush  = if_id_flush_c;
    assign hz.id_ex_flush  = id_ex_flush_c;
    assign hz.mem_stall    = mem_stall_c;
    assign hz.state        = state_q;
    assign hz.stall_cycles = stall_q;
    assign hz.flush_events = flush_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: two instances (LOAD_BUBBLES=1/CNT_WIDTH=4 and
// LOAD_BUBBLES=3/CNT_WIDTH=16) share stimulus; each step checks the selected instance.
module tb_hazard_controller;
    typedef struct packed {
        logic       rst_v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       mq;
        logic       mrdy;
    } stim_t;

    typedef struct {
        string      tag;
        int         sel;
        logic [6:0] ctl;
        int         sc;
        int         fe;
    } exp_t;

    // ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush, mem_stall, state[1:0]}
    localparam logic [6:0] C_RUN = 7'b1100000;
    localparam logic [6:0] C_RST = 7'b0011000;

    logic  clk;
    logic  rst;
    stim_t stim;
    exp_t  sb_q[$];
    exp_t  mon_e;
    int    n_cmp;
    int    n_err;

    hazard_controller_if #(.CNT_WIDTH(4))  if_a ();
    hazard_controller_if #(.CNT_WIDTH(16)) if_b ();

    hazard_controller #(.LOAD_BUBBLES(1), .CNT_WIDTH(4)) u_a (
        .clk (clk),
        .rst (rst),
        .hz  (if_a)
    );

    hazard_controller #(.LOAD_BUBBLES(3), .CNT_WIDTH(16)) u_b (
        .clk (clk),
        .rst (rst),
        .hz  (if_b)
    );

    assign rst = stim.rst_v;

    assign if_a.id_rs1          = stim.rs1;
    assign if_a.id_rs2          = stim.rs2;
    assign if_a.id_uses_rs1     = stim.u1;
    assign if_a.id_uses_rs2     = stim.u2;
    assign if_a.ex_rd           = stim.rd;
    assign if_a.ex_mem_read     = stim.mr;
    assign if_a.ex_branch_taken = stim.br;
    assign if_a.mem_req         = stim.mq;
    assign if_a.mem_ready       = stim.mrdy;

    assign if_b.id_rs1          = stim.rs1;
    assign if_b.id_rs2          = stim.rs2;
    assign if_b.id_uses_rs1     = stim.u1;
    assign if_b.id_uses_rs2     = stim.u2;
    assign if_b.ex_rd           = stim.rd;
    assign if_b.ex_mem_read     = stim.mr;
    assign if_b.ex_branch_taken = stim.br;
    assign if_b.mem_req         = stim.mq;
    assign if_b.mem_ready       = stim.mrdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s       = '0;
        s.rst_v = 1'b1;
        return s;
    endfunction

    function automatic stim_t in_reset();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t lu_rs1();
        stim_t s;
        s     = idle();
        s.rs1 = 5'd5;
        s.u1  = 1'b1;
        s.rd  = 5'd5;
        s.mr  = 1'b1;
        return s;
    endfunction

    function automatic logic [6:0] c_bub(input logic [1:0] st);
        return {5'b00010, st};
    endfunction

    function automatic logic [6:0] c_br(input logic [1:0] st);
        return {5'b11110, st};
    endfunction

    function automatic logic [6:0] c_mw(input logic [1:0] st);
        return {5'b00001, st};
    endfunction

    // Apply one cycle of stimulus just after the rising edge and queue what it must produce.
    task automatic step(input string tag, input int sel, input stim_t s,
                        input logic [6:0] ctl, input int sc, input int fe);
        exp_t e;
        @(posedge clk);
        #1;
        stim  = s;
        e.tag = tag;
        e.sel = sel;
        e.ctl = ctl;
        e.sc  = sc;
        e.fe  = fe;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.sel == 0) begin
                check({mon_e.tag, "_ctl"},
                      32'({if_a.pc_write, if_a.if_id_write, if_a.if_id_flush,
                           if_a.id_ex_flush, if_a.mem_stall, if_a.state}),
                      32'(mon_e.ctl));
                check({mon_e.tag, "_stall"}, 32'(if_a.stall_cycles), 32'(mon_e.sc));
                check({mon_e.tag, "_flush"}, 32'(if_a.flush_events), 32'(mon_e.fe));
            end else begin
                check({mon_e.tag, "_ctl"},
                      32'({if_b.pc_write, if_b.if_id_write, if_b.if_id_flush,
                           if_b.id_ex_flush, if_b.mem_stall, if_b.state}),
                      32'(mon_e.ctl));
                check({mon_e.tag, "_stall"}, 32'(if_b.stall_cycles), 32'(mon_e.sc));
                check({mon_e.tag, "_flush"}, 32'(if_b.flush_events), 32'(mon_e.fe));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t h;
        n_cmp = 0;
        n_err = 0;
        stim  = in_reset();

        // Reset values and first cycle after release.
        step("rst_a", 0, in_reset(), C_RST, 0, 0);
        step("rst_b", 1, in_reset(), C_RST, 0, 0);
        step("rel_a", 0, idle(), C_RUN, 0, 0);

        // Single-bubble load-use on rs1.
        step("lu1_bub", 0, lu_rs1(), c_bub(2'd0), 0, 0);
        step("lu1_after", 0, idle(), C_RUN, 1, 0);

        // x0 destination and unused rs2 never stall; used rs2 does.
        h = lu_rs1(); h.rd = 5'd0; h.rs1 = 5'd0;
        step("rd0", 0, h, C_RUN, 1, 0);
        h = idle(); h.rs2 = 5'd5; h.rd = 5'd5; h.mr = 1'b1;
        step("rs2_unused", 0, h, C_RUN, 1, 0);
        h.u2 = 1'b1;
        step("rs2_used", 0, h, c_bub(2'd0), 1, 0);
        step("rs2_after", 0, idle(), C_RUN, 2, 0);

        // Taken branch overrides a simultaneous load-use hazard.
        h = lu_rs1(); h.br = 1'b1;
        step("br_lu", 0, h, c_br(2'd0), 2, 0);
        step("br_after", 0, idle(), C_RUN, 2, 1);

        step("rst2", 1, in_reset(), C_RST, 0, 0);
        step("rel2", 1, idle(), C_RUN, 0, 0);

        // Three bubbles per hazard: RUN -> LOAD_STALL -> LOAD_STALL -> RUN.
        step("lb3_b1", 1, lu_rs1(), c_bub(2'd0), 0, 0);
        step("lb3_b2", 1, idle(), c_bub(2'd1), 1, 0);
        step("lb3_b3", 1, idle(), c_bub(2'd1), 2, 0);
        step("lb3_end", 1, idle(), C_RUN, 3, 0);

        // Memory wait entered from LOAD_STALL with the branch held; flush on release.
        step("mw_b1", 1, lu_rs1(), c_bub(2'd0), 3, 0);
        step("mw_b2", 1, idle(), c_bub(2'd1), 4, 0);
        h = idle(); h.mq = 1'b1; h.br = 1'b1;
        step("mw_1", 1, h, c_mw(2'd1), 5, 0);
        step("mw_2", 1, h, c_mw(2'd2), 6, 0);
        step("mw_3", 1, h, c_mw(2'd2), 7, 0);
        step("mw_4", 1, h, c_mw(2'd2), 8, 0);
        h.mrdy = 1'b1;
        step("mw_ret", 1, h, c_br(2'd2), 9, 0);
        step("mw_post", 1, idle(), C_RUN, 9, 1);
        step("mw_post2", 1, idle(), C_RUN, 9, 1);

        // Reset in LOAD_STALL with two bubbles still pending.
        step("rs_b1", 1, lu_rs1(), c_bub(2'd0), 9, 1);
        step("rs_mid", 1, in_reset(), C_RST, 0, 0);
        step("rs_rel", 1, idle(), C_RUN, 0, 0);
        step("rs_post", 1, idle(), C_RUN, 0, 0);

        // Saturation of a 4-bit stall counter over 21 stall cycles.
        step("rst3", 0, in_reset(), C_RST, 0, 0);
        step("rel3", 0, idle(), C_RUN, 0, 0);
        for (int i = 0; i < 21; i++) begin
            step($sformatf("sat%0d", i), 0, lu_rs1(), c_bub(2'd0), (i < 15) ? i : 15, 0);
        end
        step("sat_hold1", 0, idle(), C_RUN, 15, 0);
        step("sat_hold2", 0, idle(), C_RUN, 15, 0);

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            check("sb_drain", 32'(sb_q.size()), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
